// File: rtl/fsqrt_iter.sv
// FloPoCo-format square root: restoring recurrence producing one root bit per clock, then round-to-nearest.
// Latency WF+4 cycles for normal operands and 1 cycle for specials. One operation at a time; the result is held until out_ready.
module fsqrt_iter #(
    parameter int WE = 6,
    parameter int WF = 6,
    localparam int W = WE + WF + 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] r,
    output logic         flag_invalid,
    output logic         flag_inexact,
    output logic         busy
);
    localparam int QW = WF + 2;
    localparam int MW = WF + 4;
    localparam int RW = 2 * WF + 4;
    localparam int CW = $clog2(WF + 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(WF + 1);
    localparam logic [WE:0]   BIAS     = {2'b00, {(WE-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, CALC, RND, DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [RW-1:0] r_rad;
    logic [MW-1:0] r_rem;
    logic [QW-1:0] r_q;
    logic [WE-1:0] r_exp;

    logic [1:0]    w_exn;
    logic          w_sgn;
    logic [WE-1:0] w_exp;
    logic [WF-1:0] w_frac;
    logic          w_special;
    logic [WE:0]   w_esum;
    logic [RW-1:0] w_rad;
    logic [W-1:0]  w_spec_r;
    logic          w_spec_inv;
    logic [MW-1:0] w_rem_sh;
    logic [MW-1:0] w_sub;
    logic [MW-1:0] w_diff;
    logic          w_ge;
    logic [WF:0]   w_rfrac;
    logic [WE-1:0] w_rexp;

    assign w_exn     = x[W-1:W-2];
    assign w_sgn     = x[W-3];
    assign w_exp     = x[WF+WE-1:WF];
    assign w_frac    = x[WF-1:0];
    assign w_special = (w_exn != 2'b01) || w_sgn;

    // (e + B) / 2 is the biased result exponent; its LSB says whether e - B is odd.
    assign w_esum = {1'b0, w_exp} + BIAS;
    assign w_rad  = w_esum[0] ? {1'b1, w_frac, {(WF+3){1'b0}}}
                              : {2'b01, w_frac, {(WF+2){1'b0}}};

    always_comb begin
        w_spec_r   = '0;
        w_spec_inv = 1'b0;
        if (w_exn == 2'b00) begin
            w_spec_r[W-3] = w_sgn;
        end else if (w_exn == 2'b10 && !w_sgn) begin
            w_spec_r[W-1:W-2] = 2'b10;
        end else begin
            w_spec_r[W-1:W-2] = 2'b11;
            w_spec_inv        = 1'b1;
        end
    end

    // The two dropped remainder bits are zero whenever a shift is still pending.
    assign w_rem_sh = {r_rem[MW-3:0], r_rad[RW-1:RW-2]};
    assign w_sub    = {r_q, 2'b01};
    assign w_ge     = (w_rem_sh >= w_sub);
    assign w_diff   = w_rem_sh - w_sub;

    assign w_rfrac = {1'b0, r_q[WF:1]} + {{WF{1'b0}}, r_q[0]};
    assign w_rexp  = r_exp + {{(WE-1){1'b0}}, w_rfrac[WF]};

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (in_valid) w_next = w_special ? DONE : CALC;
            CALC: if (r_cnt == CNT_LAST) w_next = RND;
            RND:  w_next = DONE;
            DONE: if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r            <= '0;
            flag_invalid <= 1'b0;
            flag_inexact <= 1'b0;
            r_cnt        <= '0;
            r_rad        <= '0;
            r_rem        <= '0;
            r_q          <= '0;
            r_exp        <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    if (w_special) begin
                        r            <= w_spec_r;
                        flag_invalid <= w_spec_inv;
                        flag_inexact <= 1'b0;
                    end else begin
                        r_rad <= w_rad;
                        r_rem <= '0;
                        r_q   <= '0;
                        r_cnt <= '0;
                        r_exp <= w_esum[WE:1];
                    end
                end
                CALC: begin
                    r_rad <= {r_rad[RW-3:0], 2'b00};
                    r_rem <= w_ge ? w_diff : w_rem_sh;
                    r_q   <= {r_q[QW-2:0], w_ge};
                    r_cnt <= r_cnt + CW'(1);
                end
                RND: begin
                    r            <= {2'b01, 1'b0, w_rexp, w_rfrac[WF-1:0]};
                    flag_invalid <= 1'b0;
                    flag_inexact <= r_q[0] || (r_rem != '0);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
endmodule

// File: tb/tb_fsqrt_iter.sv
// Bench for fsqrt_iter: two instances (6/6 and 8/23), queue scoreboard fed by the drivers,
// negedge monitors comparing every presented result against an integer-sqrt reference model.
module tb_fsqrt_iter;
    localparam int AWE = 6, AWF = 6, AW = AWE + AWF + 3;
    localparam int BWE = 8, BWF = 23, BW = BWE + BWF + 3;

    typedef struct {
        logic [63:0] r;
        bit          inv;
        bit          inx;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t qa[$];
    exp_t qb[$];
    bit   a_seen = 1'b0;
    bit   b_seen = 1'b0;

    logic          a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic          a_flag_invalid, a_flag_inexact, a_busy;
    logic [AW-1:0] a_x, a_r;
    logic          b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic          b_flag_invalid, b_flag_inexact, b_busy;
    logic [BW-1:0] b_x, b_r;

    fsqrt_iter #(.WE(AWE), .WF(AWF)) u_a (
        .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .x(a_x),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .r(a_r),
        .flag_invalid(a_flag_invalid), .flag_inexact(a_flag_inexact), .busy(a_busy)
    );
    fsqrt_iter #(.WE(BWE), .WF(BWF)) u_b (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .x(b_x),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .r(b_r),
        .flag_invalid(b_flag_invalid), .flag_inexact(b_flag_inexact), .busy(b_busy)
    );

    function automatic void chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    // Reference: exact integer square root of the scaled radicand, rounded half-up on the guard bit.
    function automatic void ref_sqrt(input int we, input int wf, input logic [63:0] xv,
                                     output logic [63:0] rv, output bit inv, output bit inx, output int lat);
        int         w;
        longint     e, f, bias, se, re, rad, q, t, rnd, frac;
        logic [1:0] exn;
        bit         sgn;
        w    = we + wf + 3;
        exn  = 2'((xv >> (w - 2)) & 64'd3);
        sgn  = xv[w-3];
        e    = longint'((xv >> wf) & ((64'd1 << we) - 64'd1));
        f    = longint'(xv & ((64'd1 << wf) - 64'd1));
        bias = (longint'(1) << (we - 1)) - 1;
        rv   = '0;
        inv  = 1'b0;
        inx  = 1'b0;
        lat  = 1;
        if (exn == 2'b00) begin
            rv = 64'(sgn) << (w - 3);
        end else if (exn == 2'b10 && !sgn) begin
            rv = 64'd2 << (w - 2);
        end else if (exn != 2'b01 || sgn) begin
            rv  = 64'd3 << (w - 2);
            inv = 1'b1;
        end else begin
            se = e - bias;
            if ((se & 1) == 0) begin
                re  = se / 2 + bias;
                rad = ((longint'(1) << wf) + f) << (wf + 2);
            end else begin
                re  = (se - 1) / 2 + bias;
                rad = ((longint'(1) << wf) + f) << (wf + 3);
            end
            q = 0;
            for (int b = wf + 2; b >= 0; b--) begin
                t = q | (longint'(1) << b);
                if (t * t <= rad) q = t;
            end
            rnd = (q + 1) >> 1;
            if (rnd == (longint'(1) << (wf + 1))) begin
                re   = re + 1;
                frac = 0;
            end else begin
                frac = rnd - (longint'(1) << wf);
            end
            inx = ((q & 1) != 0) || (q * q != rad);
            rv  = (64'd1 << (w - 2)) | (64'(re) << wf) | 64'(frac);
            lat = wf + 4;
        end
    endfunction

    function automatic void mon_cmp(input string tag, input logic [63:0] act_r, input logic inv,
                                    input logic inx, input logic inr, input exp_t e, input bit first);
        chk(act_r === e.r, {tag, "_r"}, act_r, e.r);
        chk({inv, inx} === {e.inv, e.inx}, {tag, "_flags"}, 64'({inv, inx}), 64'({e.inv, e.inx}));
        chk(inr === 1'b0, {tag, "_in_ready_while_done"}, 64'(inr), 64'd0);
        if (first) chk(cyc - e.acc + 1 == e.lat, {tag, "_latency"}, 64'(cyc - e.acc + 1), 64'(e.lat));
    endfunction

    always @(negedge clk) begin
        if (a_rst === 1'b0 && a_out_valid === 1'b1) begin
            if (qa.size() == 0) begin
                chk(1'b0, "a_unexpected_out_valid", 64'(a_r), 64'd0);
            end else begin
                mon_cmp("a", 64'(a_r), a_flag_invalid, a_flag_inexact, a_in_ready, qa[0], !a_seen);
                a_seen = 1'b1;
                if (a_out_ready === 1'b1) begin
                    void'(qa.pop_front());
                    a_seen = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (b_rst === 1'b0 && b_out_valid === 1'b1) begin
            if (qb.size() == 0) begin
                chk(1'b0, "b_unexpected_out_valid", 64'(b_r), 64'd0);
            end else begin
                mon_cmp("b", 64'(b_r), b_flag_invalid, b_flag_inexact, b_in_ready, qb[0], !b_seen);
                b_seen = 1'b1;
                if (b_out_ready === 1'b1) begin
                    void'(qb.pop_front());
                    b_seen = 1'b0;
                end
            end
        end
    end

    task automatic send_a(input logic [AW-1:0] xv, input logic [63:0] er, input bit ei, input bit ex, input int el);
        exp_t ent;
        int   n = 0;
        a_x        = xv;
        a_in_valid = 1'b1;
        while (a_in_ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        chk(a_in_ready === 1'b1, "a_accept_timeout", 64'(a_in_ready), 64'd1);
        @(posedge clk); #1;
        ent.r = er; ent.inv = ei; ent.inx = ex; ent.lat = el; ent.acc = cyc;
        qa.push_back(ent);
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [BW-1:0] xv, input logic [63:0] er, input bit ei, input bit ex, input int el);
        exp_t ent;
        int   n = 0;
        b_x        = xv;
        b_in_valid = 1'b1;
        while (b_in_ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        chk(b_in_ready === 1'b1, "b_accept_timeout", 64'(b_in_ready), 64'd1);
        @(posedge clk); #1;
        ent.r = er; ent.inv = ei; ent.inx = ex; ent.lat = el; ent.acc = cyc;
        qb.push_back(ent);
        b_in_valid = 1'b0;
    endtask

    task automatic drain_a();
        int n = 0;
        while (qa.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
        chk(qa.size() == 0, "a_drain_timeout", 64'(qa.size()), 64'd0);
    endtask

    task automatic drain_b();
        int n = 0;
        while (qb.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
        chk(qb.size() == 0, "b_drain_timeout", 64'(qb.size()), 64'd0);
    endtask

    task automatic check_idle_a(input string tag);
        chk(a_in_ready === 1'b1, {tag, "_in_ready"}, 64'(a_in_ready), 64'd1);
        chk(a_out_valid === 1'b0, {tag, "_out_valid"}, 64'(a_out_valid), 64'd0);
        chk(a_busy === 1'b0, {tag, "_busy"}, 64'(a_busy), 64'd0);
    endtask

    logic [AW-1:0] d_x   [7] = '{15'h27C0, 15'h2840, 15'h2800, 15'h3840, 15'h1000, 15'h4000, 15'h6000};
    logic [AW-1:0] d_r   [7] = '{15'h27C0, 15'h2800, 15'h27DB, 15'h6000, 15'h1000, 15'h4000, 15'h6000};
    bit            d_inv [7] = '{0, 0, 0, 1, 0, 0, 1};
    bit            d_inx [7] = '{0, 0, 1, 0, 0, 0, 0};
    int            d_lat [7] = '{10, 10, 10, 1, 1, 1, 1};

    task automatic run_a();
        logic [63:0] xv, er;
        bit          ei, ex;
        int          el, k, n;
        a_rst = 1'b1; a_in_valid = 1'b1; a_x = 15'h27C0; a_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle_a("a_reset");
        chk(a_r === '0, "a_reset_r", 64'(a_r), 64'd0);
        chk({a_flag_invalid, a_flag_inexact} === 2'b00, "a_reset_flags", 64'({a_flag_invalid, a_flag_inexact}), 64'd0);
        a_rst = 1'b0; a_in_valid = 1'b0;

        for (int i = 0; i < 7; i++) send_a(d_x[i], 64'(d_r[i]), d_inv[i], d_inx[i], d_lat[i]);
        drain_a();

        // Backpressure: result held for 20 cycles while a stray operand is offered.
        a_out_ready = 1'b0;
        send_a(15'h2840, 64'h2800, 1'b0, 1'b0, 10);
        n = 0;
        while (a_out_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        chk(a_out_valid === 1'b1, "a_bp_out_valid_timeout", 64'(a_out_valid), 64'd1);
        a_in_valid = 1'b1; a_x = 15'h27C0;
        repeat (20) begin @(posedge clk); #1; end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        check_idle_a("a_after_release");
        a_out_ready = 1'b1;
        repeat (15) begin @(posedge clk); #1; end
        drain_a();

        // Reset in the third CALC cycle discards the operation.
        send_a(15'h2800, 64'h27DB, 1'b0, 1'b1, 10);
        repeat (2) begin @(posedge clk); #1; end
        a_rst = 1'b1;
        qa.delete();
        a_seen = 1'b0;
        @(posedge clk); #1;
        a_rst = 1'b0;
        check_idle_a("a_mid_reset");
        repeat (15) begin @(posedge clk); #1; end
        send_a(15'h2840, 64'h2800, 1'b0, 1'b0, 10);
        drain_a();

        for (int i = 0; i < 60; i++) begin
            xv = 64'($urandom) & 64'h7FFF;
            k  = $urandom_range(0, 9);
            if (k < 7) begin
                xv[14:13] = 2'b01;
                if (k < 5) xv[12] = 1'b0;
            end
            ref_sqrt(AWE, AWF, xv, er, ei, ex, el);
            send_a(xv[AW-1:0], er, ei, ex, el);
        end
        drain_a();
    endtask

    task automatic run_b();
        logic [63:0] xv, er;
        bit          ei, ex;
        int          el, k;
        b_rst = 1'b1; b_in_valid = 1'b1; b_x = '0; b_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk(b_in_ready === 1'b1, "b_reset_in_ready", 64'(b_in_ready), 64'd1);
        chk(b_out_valid === 1'b0, "b_reset_out_valid", 64'(b_out_valid), 64'd0);
        chk(b_r === '0, "b_reset_r", 64'(b_r), 64'd0);
        b_rst = 1'b0; b_in_valid = 1'b0;

        for (int i = 0; i < 40; i++) begin
            xv = {$urandom, $urandom} & ((64'd1 << BW) - 64'd1);
            k  = $urandom_range(0, 9);
            if (k < 7) begin
                xv[BW-1:BW-2] = 2'b01;
                if (k < 5) xv[BW-3] = 1'b0;
            end
            ref_sqrt(BWE, BWF, xv, er, ei, ex, el);
            send_b(xv[BW-1:0], er, ei, ex, el);
        end
        drain_b();
    endtask

    initial begin
        fork
            run_a();
            run_b();
        join
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end
endmodule
